hilo_mdu_ctrl: RTL

- Multi-cycle multiply/divide scheduler that owns the architectural HI/LO registers.
- Sits beside the execute stage. Accepts MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO from decode.
- Sequences a pipelined multiplier and a 32-iteration restoring divider.
- Exports vhi/vlo for MFHI/MFLO write-back, plus a ready/busy handshake used by the pipeline stall logic.

---
 rtl/hilo_mdu_ctrl.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multi-cycle multiply/divide scheduler owning the HI/LO pair.
//
// Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU (pipelined multiplier, MUL_LAT
// edges), DIV/DIVU (setup edge + 32-step restoring divider) and MTHI/MTLO
// (single cycle) from decode, and publishes HI/LO for MFHI/MFLO write-back.
//
// Ports:
//   clk       core clock
//   resetn    synchronous active-low reset
//   in_valid  decoded op and operands valid
//   in_ready  controller idle and able to accept an op
//   op        decoded op (non-MDU encodings are ignored)
//   va, vb    rs / rt operands
//   flush     kills the in-flight op; blocks acceptance in idle
//   busy      multi-cycle op in flight
//   done      one-cycle pulse after a multi-cycle op updated HI/LO
//   vhi, vlo  architectural HI / LO registers
//
// Optional build macro HILO_MDU_EARLY_OUT_EN: divides whose quotient is
// trivially zero (|va| < |vb|) or whose divisor is zero finish on the
// setup edge instead of iterating.

package hilo_mdu_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10,
        OP_OTHER = 4'd15
    } op_t;
endpackage

module hilo_mdu_ctrl
    import hilo_mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         op,
    input  logic [31:0] va,
    input  logic [31:0] vb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] vhi,
    output logic [31:0] vlo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);

    function automatic logic is_mdu(input op_t o);
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO: is_mdu = 1'b1;
            default:                             is_mdu = 1'b0;
        endcase
    endfunction

    function automatic logic is_mul(input op_t o);
        case (o)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
            default:                                                 is_mul = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(input op_t o);
        case (o)
            OP_MULT, OP_MADD, OP_MSUB, OP_DIV: is_signed = 1'b1;
            default:                           is_signed = 1'b0;
        endcase
    endfunction

    // 0: overwrite, 1: accumulate, 2: subtract from HI/LO
    function automatic logic [1:0] acc_mode(input op_t o);
        case (o)
            OP_MADD, OP_MADDU: acc_mode = 2'd1;
            OP_MSUB, OP_MSUBU: acc_mode = 2'd2;
            default:           acc_mode = 2'd0;
        endcase
    endfunction

    // Magnitude of a possibly-signed operand; 0x80000000 maps to itself.
    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        mag = (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] hi_r, lo_r;
    logic [5:0]  cnt_r;
    logic [31:0] a_r, b_r;
    logic        sgn_r;
    logic [1:0]  acc_mode_r;
    logic [63:0] prod_r;
    logic [31:0] q_r, rem_r, d_r;
    logic        neg_q_r, neg_r_r;
    logic        busy_r, done_r, in_ready_r;

    logic        accept_s, mul_wr_s, div_wr_s, early_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s, mul_res_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [32:0] rem_sh_s, diff_s;
    logic [31:0] rem_nxt_s, q_nxt_s;
    logic [31:0] div_hi_s, div_lo_s;

    assign accept_s = in_valid && (state_r == ST_IDLE) && !flush && is_mdu(op);

    // First multiplier stage: the full 64-bit product is formed at accept;
    // sign-extending to 64 bits makes the low half correct for both signednesses.
    assign mul_a_s = {{32{is_signed(op) & va[31]}}, va};
    assign mul_b_s = {{32{is_signed(op) & vb[31]}}, vb};
    assign prod_s  = mul_a_s * mul_b_s;

    assign mag_a_s = mag(a_r, sgn_r);
    assign mag_b_s = mag(b_r, sgn_r);

`ifdef HILO_MDU_EARLY_OUT_EN
    assign early_s = (b_r == 32'd0) || (mag_a_s < mag_b_s);
`else
    assign early_s = 1'b0;
`endif

    // Multiply write-back value, applied against HI/LO as they stand at the write edge.
    always_comb begin
        mul_res_s = prod_r;
        case (acc_mode_r)
            2'd1:    mul_res_s = {hi_r, lo_r} + prod_r;
            2'd2:    mul_res_s = {hi_r, lo_r} - prod_r;
            default: mul_res_s = prod_r;
        endcase
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_s = {rem_r, q_r[31]};
        diff_s   = rem_sh_s - {1'b0, d_r};
        if (rem_sh_s >= {1'b0, d_r}) begin
            rem_nxt_s = diff_s[31:0];
            q_nxt_s   = {q_r[30:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[31:0];
            q_nxt_s   = {q_r[30:0], 1'b0};
        end
    end

    // Divide result: zero divisor and early-out bypass the iteration result.
    always_comb begin
        div_hi_s = a_r;
        div_lo_s = 32'hFFFF_FFFF;
        if (b_r == 32'd0) begin
            div_hi_s = a_r;
            div_lo_s = 32'hFFFF_FFFF;
        end else if (cnt_r == 6'd0) begin
            div_hi_s = a_r;
            div_lo_s = 32'd0;
        end else begin
            div_lo_s = neg_q_r ? (32'd0 - q_nxt_s) : q_nxt_s;
            div_hi_s = neg_r_r ? (32'd0 - rem_nxt_s) : rem_nxt_s;
        end
    end

    // Next-state and write-strobe decode; flush suppresses any write.
    always_comb begin
        state_nxt_s = state_r;
        mul_wr_s    = 1'b0;
        div_wr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul(op)) begin
                    state_nxt_s = ST_MUL;
                end else if (accept_s && (op == OP_DIV || op == OP_DIVU)) begin
                    state_nxt_s = ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == MUL_LAST) begin
                    mul_wr_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if ((cnt_r == 6'd0 && early_s) || cnt_r == 6'd32) begin
                    div_wr_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, operand latches, divider datapath and HI/LO.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            cnt_r      <= 6'd0;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            sgn_r      <= 1'b0;
            acc_mode_r <= 2'd0;
            prod_r     <= 64'd0;
            q_r        <= 32'd0;
            rem_r      <= 32'd0;
            d_r        <= 32'd0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            in_ready_r <= (state_nxt_s == ST_IDLE);
            done_r     <= 1'b0;
            if (accept_s) begin
                a_r        <= va;
                b_r        <= vb;
                sgn_r      <= is_signed(op);
                acc_mode_r <= acc_mode(op);
                prod_r     <= prod_s;
                cnt_r      <= 6'd0;
                if (op == OP_MTHI) begin
                    hi_r <= va;
                end else if (op == OP_MTLO) begin
                    lo_r <= va;
                end else begin
                    hi_r <= hi_r;
                end
            end else if (state_r == ST_MUL) begin
                cnt_r <= cnt_r + 6'd1;
                if (mul_wr_s) begin
                    {hi_r, lo_r} <= mul_res_s;
                    done_r       <= 1'b1;
                end
            end else if (state_r == ST_DIV) begin
                cnt_r <= cnt_r + 6'd1;
                if (cnt_r == 6'd0) begin
                    // setup edge: move to magnitudes and record result signs
                    q_r     <= mag_a_s;
                    d_r     <= mag_b_s;
                    rem_r   <= 32'd0;
                    neg_q_r <= sgn_r & (a_r[31] ^ b_r[31]);
                    neg_r_r <= sgn_r & a_r[31];
                end else begin
                    q_r   <= q_nxt_s;
                    rem_r <= rem_nxt_s;
                end
                if (div_wr_s) begin
                    hi_r   <= div_hi_s;
                    lo_r   <= div_lo_s;
                    done_r <= 1'b1;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign vhi      = hi_r;
    assign vlo      = lo_r;

endmodule
